nios_buttons: RTL and testbench



---
 rtl/nios_buttons_pkg.sv | 14 +
 rtl/nios_buttons_if.sv | 22 ++
 rtl/nios_buttons_filter.sv | 45 ++++
 rtl/nios_buttons.sv | 110 +++++++++++
 tb/tb_nios_buttons.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/nios_buttons_pkg.sv
// Shared constants for the nios_buttons input PIO.
// Register addresses and edge-select encodings.
package nios_buttons_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_buttons_if.sv
// Avalon-MM slave bus plus interrupt line
// for the nios_buttons PIO.
interface nios_buttons_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/nios_buttons_filter.sv
// One button bit: 2-flop synchronizer, 3-sample
// history and debounced level register.
module nios_buttons_filter
   import nios_buttons_pkg::*;
#(
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic in_bit,
   output logic level
);

   logic       s1_q;
   logic       s2_q;
   logic [2:0] h_q;
   logic [2:0] h_d;
   logic       lvl_q;
   logic       lvl_d;

   always_comb begin
      h_d   = tick ? {h_q[1:0], s2_q} : h_q;
      lvl_d = lvl_q;
      // only a unanimous history moves the level
      if ((&h_q) || (~|h_q)) lvl_d = h_q[0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q  <= IDLE_LEVEL;
         s2_q  <= IDLE_LEVEL;
         h_q   <= {3{IDLE_LEVEL}};
         lvl_q <= IDLE_LEVEL;
      end else begin
         s1_q  <= in_bit;
         s2_q  <= s1_q;
         h_q   <= h_d;
         lvl_q <= lvl_d;
      end
   end

   assign level = lvl_q;

endmodule

// File: rtl/nios_buttons.sv
// Avalon-MM input PIO for push-buttons: debounced
// DATA, W1C edge capture, IRQ mask and level IRQ.
module nios_buttons
   import nios_buttons_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int DEBOUNCE_DIV = 50000,
   parameter int EDGE_TYPE    = 1,
   parameter int IDLE_LEVEL   = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   nios_buttons_if.slave    bus,
   input  logic [WIDTH-1:0] in_port
);

   localparam int CW =
      (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_DIV - 1);
   localparam logic IDLE = (IDLE_LEVEL != 0);

   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             tick;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edg;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic [WIDTH-1:0] cap_q;
   logic [WIDTH-1:0] cap_d;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] wd;
   logic             wr;
   logic [31:0]      rd;
   logic             unused_wd;

   assign tick = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_filt
      nios_buttons_filter #(
         .IDLE_LEVEL (IDLE)
      ) u_filt (
         .clk     (clk),
         .reset_n (reset_n),
         .tick    (tick),
         .in_bit  (in_port[i]),
         .level   (level[i])
      );
   end

   assign rise = level & ~prev_q;
   assign fall = ~level & prev_q;

   always_comb begin
      edg = rise | fall;
      case (EDGE_TYPE)
         EDGE_RISING:  edg = rise;
         EDGE_FALLING: edg = fall;
         default:      edg = rise | fall;
      endcase
   end

   assign wr        = bus.chipselect & ~bus.write_n;
   assign wd        = bus.writedata[WIDTH-1:0];
   assign unused_wd = ^bus.writedata;

   always_comb begin
      mask_d = mask_q;
      clr    = '0;
      if (wr && bus.address == ADDR_IRQMASK) mask_d = wd;
      if (wr && bus.address == ADDR_EDGECAP) clr = wd;
      // a new edge outranks a clear in the same cycle
      cap_d = (cap_q & ~clr) | edg;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         prev_q <= {WIDTH{IDLE}};
         mask_q <= '0;
         cap_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         prev_q <= level;
         mask_q <= mask_d;
         cap_q  <= cap_d;
      end
   end

   always_comb begin
      rd = '0;
      case (bus.address)
         ADDR_DATA:    rd[WIDTH-1:0] = level;
         ADDR_IRQMASK: rd[WIDTH-1:0] = mask_q;
         ADDR_EDGECAP: rd[WIDTH-1:0] = cap_q;
         default:      rd = '0;
      endcase
   end

   assign bus.readdata = rd;
   assign bus.irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_buttons.sv
// Directed bench for nios_buttons: vector table on a
// DIV=1 instance, hand sequences for debounce and reset.
module tb_nios_buttons;
   import nios_buttons_pkg::*;

   typedef struct {
      logic        cs;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [3:0]  inp;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] in_a;
   logic [3:0] in_b;
   vec_t       tbl[$];
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   nios_buttons_if ifa ();
   nios_buttons_if ifb ();

   nios_buttons #(
      .WIDTH(4), .DEBOUNCE_DIV(1), .EDGE_TYPE(1), .IDLE_LEVEL(1)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ifa), .in_port(in_a)
   );

   nios_buttons #(
      .WIDTH(4), .DEBOUNCE_DIV(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ifb), .in_port(in_b)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic add(input logic cs, input logic wr,
                      input logic [1:0] a, input logic [31:0] wd,
                      input logic [3:0] inp, input logic [31:0] er,
                      input logic ei);
      tbl.push_back('{cs, wr, a, wd, inp, er, ei});
   endtask

   task automatic rd_a(input logic [1:0] a, output logic [31:0] d);
      ifa.address = a;
      #1 d = ifa.readdata;
   endtask

   task automatic rd_b(input logic [1:0] a, output logic [31:0] d);
      ifb.address = a;
      #1 d = ifb.readdata;
   endtask

   task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      ifa.chipselect = 1'b1;
      ifa.write_n    = 1'b0;
      ifa.address    = a;
      ifa.writedata  = d;
      @(negedge clk);
      ifa.chipselect = 1'b0;
      ifa.write_n    = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic        bad;

      reset_n = 1'b0;
      in_a = 4'hF;
      in_b = 4'hF;
      ifa.chipselect = 1'b0; ifa.write_n = 1'b1;
      ifa.address = 2'd0;    ifa.writedata = '0;
      ifb.chipselect = 1'b0; ifb.write_n = 1'b1;
      ifb.address = 2'd0;    ifb.writedata = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // reset state on both instances
      rd_a(ADDR_DATA, d);    check("rst_a_data", d, 32'hF);
      rd_a(ADDR_IRQMASK, d); check("rst_a_mask", d, 32'h0);
      rd_a(ADDR_EDGECAP, d); check("rst_a_cap", d, 32'h0);
      rd_a(ADDR_RSVD, d);    check("rst_a_rsvd", d, 32'h0);
      check("rst_a_irq", {31'b0, ifa.irq}, 32'h0);
      rd_b(ADDR_DATA, d);    check("rst_b_data", d, 32'hF);
      check("rst_b_irq", {31'b0, ifb.irq}, 32'h0);

      // DIV=4: two-tick glitch on bit 2 must be filtered
      ifb.address = ADDR_DATA;
      bad = 1'b0;
      @(negedge clk);
      in_b = 4'hB;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (i == 7) in_b = 4'hF;
         #1 if (ifb.readdata !== 32'hF) bad = 1'b1;
      end
      check("glitch_level_moved", {31'b0, bad}, 32'h0);
      rd_b(ADDR_EDGECAP, d); check("glitch_cap", d, 32'h0);

      // DIV=4: sustained press settles within 11..15 cycles
      @(negedge clk);
      in_b = 4'hB;
      repeat (10) @(negedge clk);
      rd_b(ADDR_DATA, d);    check("div4_early", d, 32'hF);
      repeat (5) @(negedge clk);
      rd_b(ADDR_DATA, d);    check("div4_level", d, 32'hB);
      @(negedge clk);
      rd_b(ADDR_EDGECAP, d); check("div4_cap", d, 32'h4);
      check("div4_irq", {31'b0, ifb.irq}, 32'h0);

      // DIV=1 vector table, one row per cycle
      add(1, 1, 2, 1, 4'hF, 32'h0, 0);
      add(1, 0, 2, 0, 4'hE, 32'h1, 0);
      for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 4'hE, 32'hF, 0);
      add(1, 0, 0, 0, 4'hE, 32'hE, 0);
      add(1, 0, 3, 0, 4'hE, 32'h1, 1);
      add(1, 1, 3, 1, 4'hE, 32'h1, 1);
      add(1, 1, 2, 0, 4'hE, 32'h1, 0);
      add(1, 0, 3, 0, 4'hC, 32'h0, 0);
      add(1, 0, 2, 0, 4'hC, 32'h0, 0);
      for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 4'hC, 32'hE, 0);
      add(1, 0, 0, 0, 4'hC, 32'hC, 0);
      add(1, 0, 3, 0, 4'hC, 32'h2, 0);
      add(1, 1, 2, 2, 4'hC, 32'h0, 0);
      add(1, 0, 3, 0, 4'hC, 32'h2, 1);
      add(1, 1, 3, 2, 4'hD, 32'h2, 1);
      add(1, 0, 3, 0, 4'hD, 32'h0, 0);
      for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 4'hD, 32'hC, 0);
      add(1, 0, 0, 0, 4'hD, 32'hD, 0);
      add(1, 0, 3, 0, 4'hD, 32'h0, 0);
      for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 4'hC, 32'hD, 0);
      add(1, 1, 3, 1, 4'hC, 32'h0, 0);
      add(1, 0, 3, 0, 4'hC, 32'h1, 0);
      add(1, 1, 3, 0, 4'hC, 32'h1, 0);
      add(1, 0, 3, 0, 4'hC, 32'h1, 0);
      add(1, 1, 0, 32'hFFFF_FFFF, 4'hC, 32'hC, 0);
      add(1, 1, 1, 32'hFFFF_FFFF, 4'hC, 32'h0, 0);
      add(1, 0, 1, 0, 4'hC, 32'h0, 0);
      add(1, 0, 2, 0, 4'hC, 32'h2, 0);
      add(1, 0, 3, 0, 4'hC, 32'h1, 0);
      add(1, 0, 0, 0, 4'hC, 32'hC, 0);
      add(0, 1, 2, 0, 4'hC, 32'h2, 0);
      add(1, 0, 2, 0, 4'hC, 32'h2, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         ifa.chipselect = tbl[i].cs;
         ifa.write_n    = ~tbl[i].wr;
         ifa.address    = tbl[i].addr;
         ifa.writedata  = tbl[i].wd;
         in_a           = tbl[i].inp;
         #1;
         check($sformatf("vec%0d_rd", i), ifa.readdata, tbl[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'b0, ifa.irq},
               {31'b0, tbl[i].exp_irq});
      end
      @(negedge clk);
      ifa.chipselect = 1'b0;
      ifa.write_n    = 1'b1;

      // build EDGECAP=3 with irq high, then reset mid-run
      in_a = 4'hF;
      repeat (10) @(negedge clk);
      in_a = 4'hC;
      repeat (10) @(negedge clk);
      wr_a(ADDR_IRQMASK, 32'h3);
      rd_a(ADDR_EDGECAP, d); check("pre_rst_cap", d, 32'h3);
      check("pre_rst_irq", {31'b0, ifa.irq}, 32'h1);
      #1 reset_n = 1'b0;
      #1 check("rst_irq_async", {31'b0, ifa.irq}, 32'h0);
      rd_a(ADDR_DATA, d);    check("rst2_data", d, 32'hF);
      rd_a(ADDR_IRQMASK, d); check("rst2_mask", d, 32'h0);
      rd_a(ADDR_EDGECAP, d); check("rst2_cap", d, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      rd_a(ADDR_EDGECAP, d); check("post_rst_cap_early", d, 32'h0);
      @(negedge clk);
      rd_a(ADDR_EDGECAP, d); check("post_rst_cap", d, 32'h3);
      check("post_rst_irq", {31'b0, ifa.irq}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
